// File: rtl/shift_reg_sequencer.sv
// Sequencer for an NBITS serial/parallel shift register: one load, NBITS paced shifts, done pulse.
// Optional feature macro ROTATE_EN: feed reg_q[0] back into the register MSB instead of ser_in.
module shift_reg_sequencer #(
    parameter int NBITS         = 4,
    parameter int TICKS_PER_BIT = 4
) (
    input  logic                       clk_2,
    input  logic                       reset_n,
    input  logic                       start,
    input  logic                       abort,
    input  logic [NBITS-1:0]           par_data,
    input  logic                       ser_in,
    input  logic [NBITS-1:0]           reg_q,
    output logic                       reg_clr,
    output logic                       reg_load,
    output logic                       reg_shift,
    output logic [NBITS-1:0]           reg_par,
    output logic                       reg_ser,
    output logic                       busy,
    output logic                       done,
    output logic [$clog2(NBITS+1)-1:0] bit_cnt
);

    localparam int CW = $clog2(NBITS + 1);
    localparam int TW = (TICKS_PER_BIT > 1) ? $clog2(TICKS_PER_BIT) : 1;
    localparam logic [TW-1:0] TICK_LAST = TW'(TICKS_PER_BIT - 1);
    localparam logic [CW-1:0] CNT_FULL  = CW'(NBITS);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_SHIFT,
        S_DONE,
        S_CLEAR
    } state_t;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TW-1:0]    r_tick;
    logic [TW-1:0]    w_tick_nxt;
    logic [CW-1:0]    r_bit_cnt;
    logic [CW-1:0]    w_bit_cnt_nxt;
    logic [NBITS-1:0] r_hold;
    logic [NBITS-1:0] w_hold_nxt;

    logic             r_clr;
    logic             r_load;
    logic             r_shift;
    logic             r_busy;
    logic             r_done;
    logic [NBITS-1:0] r_par;

    logic             w_clr_nxt;
    logic             w_load_nxt;
    logic             w_shift_nxt;
    logic             w_busy_nxt;
    logic             w_done_nxt;
    logic [NBITS-1:0] w_par_nxt;
    logic             w_ser;
    logic             w_unused_inputs;

    // State register; outputs are registered alongside the state so they never glitch.
    always_ff @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit_cnt <= '0;
            r_hold    <= '0;
            r_clr     <= 1'b0;
            r_load    <= 1'b0;
            r_shift   <= 1'b0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
            r_par     <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit_cnt <= w_bit_cnt_nxt;
            r_hold    <= w_hold_nxt;
            r_clr     <= w_clr_nxt;
            r_load    <= w_load_nxt;
            r_shift   <= w_shift_nxt;
            r_busy    <= w_busy_nxt;
            r_done    <= w_done_nxt;
            r_par     <= w_par_nxt;
        end
    end

    // Abort is checked before the tick so an abort always suppresses a pending shift.
    always_comb begin
        w_state_nxt = r_state;
        w_tick_nxt  = r_tick;
        w_hold_nxt  = r_hold;
        unique case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_nxt = S_LOAD;
                    w_hold_nxt  = par_data;
                end
            end
            S_LOAD: begin
                if (abort) begin
                    w_state_nxt = S_CLEAR;
                end else begin
                    w_state_nxt = S_SHIFT;
                    w_tick_nxt  = '0;
                end
            end
            S_SHIFT: begin
                if (abort) begin
                    w_state_nxt = S_CLEAR;
                end else if (r_bit_cnt == CNT_FULL) begin
                    w_state_nxt = S_DONE;
                end else begin
                    w_tick_nxt = (r_tick == TICK_LAST) ? '0 : r_tick + 1'b1;
                end
            end
            S_DONE:  w_state_nxt = S_IDLE;
            S_CLEAR: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Output values for the coming cycle, derived from the next state and next tick.
    always_comb begin
        w_load_nxt    = (w_state_nxt == S_LOAD);
        w_shift_nxt   = (w_state_nxt == S_SHIFT) && (w_tick_nxt == TICK_LAST);
        w_clr_nxt     = (w_state_nxt == S_CLEAR);
        w_done_nxt    = (w_state_nxt == S_DONE);
        w_busy_nxt    = (w_state_nxt == S_LOAD) || (w_state_nxt == S_SHIFT) ||
                        (w_state_nxt == S_CLEAR);
        w_par_nxt     = w_load_nxt ? w_hold_nxt : '0;
        w_bit_cnt_nxt = r_bit_cnt;
        if (w_load_nxt) begin
            w_bit_cnt_nxt = '0;
        end else if (w_shift_nxt) begin
            w_bit_cnt_nxt = r_bit_cnt + 1'b1;
        end
    end

`ifdef ROTATE_EN
    assign w_ser = reg_q[0];
`else
    assign w_ser = ser_in;
`endif

    // Only one of the two serial sources is used per build.
    assign w_unused_inputs = ^{reg_q, ser_in};

    assign reg_clr   = r_clr;
    assign reg_load  = r_load;
    assign reg_shift = r_shift;
    assign reg_par   = r_par;
    assign reg_ser   = reset_n & w_ser;
    assign busy      = r_busy;
    assign done      = r_done;
    assign bit_cnt   = r_bit_cnt;

    always_ff @(posedge clk_2) begin
        if (reset_n) begin
            assert ($onehot0({r_clr, r_load, r_shift}));
        end
    end

endmodule

// File: tb/tb_shift_reg_sequencer.sv
// Scoreboard bench for shift_reg_sequencer: pulse events are queued by the stimulus and popped by a monitor.
// Expected register contents follow the ROTATE_EN build option.
module tb_shift_reg_sequencer;

    localparam int NBITS  = 4;
    localparam int TPB    = 4;
    localparam int K_LOAD  = 1;
    localparam int K_SHIFT = 2;
    localparam int K_DONE  = 3;
    localparam int K_CLR   = 4;

    logic       clk_2 = 1'b0;
    logic       reset_n;
    logic       start;
    logic       startFast;
    logic       abort;
    logic [3:0] par_data;
    logic       ser_in;
    logic [3:0] regQ;

    logic       regClr, regLoad, regShift, regSer, busy, done;
    logic [3:0] regPar;
    logic [2:0] bitCnt;
    logic       fClr, fLoad, fShift, fSer, fBusy, fDone;
    logic [3:0] fPar;
    logic [2:0] fBitCnt;

    typedef struct {
        int dut;
        int cyc;
        int kind;
        int val;
    } evT;

    evT         expQ[$];
    int         cyc = 0;
    int         errors = 0;
    int         checks = 0;
    logic [3:0] expB[4];

    always #5 clk_2 = ~clk_2;

    always @(posedge clk_2) cyc <= cyc + 1;

    shift_reg_sequencer #(.NBITS(NBITS), .TICKS_PER_BIT(TPB)) u_dut (
        .clk_2(clk_2), .reset_n(reset_n), .start(start), .abort(abort),
        .par_data(par_data), .ser_in(ser_in), .reg_q(regQ),
        .reg_clr(regClr), .reg_load(regLoad), .reg_shift(regShift),
        .reg_par(regPar), .reg_ser(regSer), .busy(busy), .done(done),
        .bit_cnt(bitCnt)
    );

    shift_reg_sequencer #(.NBITS(NBITS), .TICKS_PER_BIT(1)) u_fast (
        .clk_2(clk_2), .reset_n(reset_n), .start(startFast), .abort(1'b0),
        .par_data(par_data), .ser_in(ser_in), .reg_q(4'b0000),
        .reg_clr(fClr), .reg_load(fLoad), .reg_shift(fShift),
        .reg_par(fPar), .reg_ser(fSer), .busy(fBusy), .done(fDone),
        .bit_cnt(fBitCnt)
    );

    // Behavioural model of the controlled register, driven only by the sequencer outputs.
    always @(posedge clk_2 or negedge reset_n) begin
        if (!reset_n)      regQ <= 4'b0000;
        else if (regClr)   regQ <= 4'b0000;
        else if (regLoad)  regQ <= regPar;
        else if (regShift) regQ <= {regSer, regQ[3:1]};
    end

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expVal);
        checks++;
        if (act !== expVal) begin
            errors++;
            $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, expVal, cyc);
        end
    endtask

    task automatic pushEv(input int dut, input int c, input int kind, input int val);
        evT e;
        e.dut  = dut;
        e.cyc  = c;
        e.kind = kind;
        e.val  = val;
        expQ.push_back(e);
    endtask

    task automatic pushTransfer(input int dut, input int c0, input int tpb, input int par);
        pushEv(dut, c0 + 1, K_LOAD, par);
        for (int k = 1; k <= NBITS; k++) pushEv(dut, c0 + 1 + k * tpb, K_SHIFT, k);
        pushEv(dut, c0 + 2 + NBITS * tpb, K_DONE, NBITS);
    endtask

    task automatic observe(input int dut, input logic ld, input logic sh, input logic cl,
                           input logic dn, input logic [3:0] par, input logic [2:0] cnt);
        int n;
        int kind;
        int val;
        evT e;
        n = int'(ld) + int'(sh) + int'(cl) + int'(dn);
        if (n == 0) return;
        if (n > 1) begin
            checks++;
            errors++;
            $display("[TB] FAIL exclusive dut%0d: got %0d strobes high, expected 1 (cycle %0d)", dut, n, cyc);
            return;
        end
        kind = ld ? K_LOAD : sh ? K_SHIFT : cl ? K_CLR : K_DONE;
        val  = ld ? int'(par) : int'(cnt);
        if (expQ.size() == 0) begin
            checks++;
            errors++;
            $display("[TB] FAIL unexpected event dut%0d: got kind %0d, expected none (cycle %0d)", dut, kind, cyc);
            return;
        end
        e = expQ.pop_front();
        checkOutput("event dut", dut, e.dut);
        checkOutput("event cycle", cyc, e.cyc);
        checkOutput("event kind", kind, e.kind);
        checkOutput("event value", val, e.val);
    endtask

    always @(negedge clk_2) begin
        if (reset_n === 1'b1) begin
            observe(0, regLoad, regShift, regClr, done, regPar, bitCnt);
            observe(1, fLoad, fShift, fClr, fDone, fPar, fBitCnt);
        end
    end

    task automatic applyStimulus(input logic st, input logic ab, input logic [3:0] par, input logic ser);
        start    = st;
        abort    = ab;
        par_data = par;
        ser_in   = ser;
    endtask

    task automatic waitCycle(input int c);
        while (cyc < c) @(negedge clk_2);
    endtask

    initial begin
        #100000;
        errors++;
        $display("[TB] FAIL watchdog: got timeout, expected completion (cycle %0d)", cyc);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0;
`ifdef ROTATE_EN
        expB = '{4'b0011, 4'b1001, 4'b1100, 4'b0110};
`else
        expB = '{4'b0011, 4'b0001, 4'b0000, 4'b0000};
`endif
        reset_n   = 1'b0;
        startFast = 1'b0;
        applyStimulus(1'b0, 1'b0, 4'b0000, 1'b1);
        repeat (2) @(negedge clk_2);
        checkOutput("reset busy", busy, 0);
        checkOutput("reset reg_load", regLoad, 0);
        checkOutput("reset reg_shift", regShift, 0);
        checkOutput("reset reg_clr", regClr, 0);
        checkOutput("reset done", done, 0);
        checkOutput("reset reg_par", regPar, 0);
        checkOutput("reset reg_ser", regSer, 0);
        checkOutput("reset bit_cnt", bitCnt, 0);
        reset_n = 1'b1;
        @(negedge clk_2);

        // One shift per cycle.
        c0 = cyc;
        par_data  = 4'b0011;
        startFast = 1'b1;
        pushTransfer(1, c0, 1, 3);
        @(negedge clk_2);
        startFast = 1'b0;
        waitCycle(c0 + 3);
        checkOutput("fast busy in shift", fBusy, 1);
        waitCycle(c0 + 7);
        checkOutput("fast busy after done", fBusy, 0);
        checkOutput("fast bit_cnt after done", fBitCnt, 4);
        waitCycle(c0 + 8);

        // Basic transfer; abort while in DONE must be ignored.
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 4'b1010, 1'b1);
        pushTransfer(0, c0, TPB, 4'b1010);
        @(negedge clk_2);
        start = 1'b0;
        waitCycle(c0 + 17);
        checkOutput("A busy in shift", busy, 1);
        waitCycle(c0 + 18);
        abort = 1'b1;
`ifdef ROTATE_EN
        checkOutput("A reg_q at done", regQ, 4'b1010);
`else
        checkOutput("A reg_q at done", regQ, 4'b1111);
`endif
        waitCycle(c0 + 19);
        abort = 1'b0;
        checkOutput("A busy idle", busy, 0);
        checkOutput("A bit_cnt idle", bitCnt, 4);
        waitCycle(c0 + 21);
        checkOutput("A bit_cnt holds", bitCnt, 4);

        // Register contents after each shift.
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 4'b0110, 1'b0);
        pushTransfer(0, c0, TPB, 4'b0110);
        @(negedge clk_2);
        start = 1'b0;
        for (int k = 1; k <= NBITS; k++) begin
            waitCycle(c0 + 2 + k * TPB);
            checkOutput($sformatf("B reg_q after shift %0d", k), regQ, expB[k-1]);
        end
        waitCycle(c0 + 20);

        // Abort just before the second shift.
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 4'b1100, 1'b0);
        pushEv(0, c0 + 1, K_LOAD, 4'b1100);
        pushEv(0, c0 + 5, K_SHIFT, 1);
        pushEv(0, c0 + 9, K_CLR, 1);
        @(negedge clk_2);
        start = 1'b0;
        waitCycle(c0 + 8);
        abort = 1'b1;
        waitCycle(c0 + 9);
        abort = 1'b0;
        checkOutput("C busy in clear", busy, 1);
        waitCycle(c0 + 10);
        checkOutput("C busy after abort", busy, 0);
        checkOutput("C bit_cnt after abort", bitCnt, 1);
        checkOutput("C reg_q cleared", regQ, 0);
        waitCycle(c0 + 12);

        // Start held high restarts one cycle after IDLE; pulses while busy are ignored.
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 4'b0101, 1'b1);
        pushTransfer(0, c0, TPB, 4'b0101);
        pushTransfer(0, c0 + 19, TPB, 4'b1001);
        waitCycle(c0 + 10);
        par_data = 4'b1001;
        waitCycle(c0 + 21);
        start = 1'b0;
        waitCycle(c0 + 26);
        start = 1'b1;
        @(negedge clk_2);
        start = 1'b0;
        waitCycle(c0 + 31);
        start = 1'b1;
        @(negedge clk_2);
        start = 1'b0;
        waitCycle(c0 + 38);
        checkOutput("D busy after second", busy, 0);
        checkOutput("D bit_cnt after second", bitCnt, 4);
        waitCycle(c0 + 40);

        // Asynchronous reset in the middle of SHIFT.
        c0 = cyc;
        applyStimulus(1'b1, 1'b0, 4'b0111, 1'b1);
        pushEv(0, c0 + 1, K_LOAD, 4'b0111);
        pushEv(0, c0 + 5, K_SHIFT, 1);
        @(negedge clk_2);
        start = 1'b0;
        waitCycle(c0 + 7);
        reset_n = 1'b0;
        #1;
        checkOutput("E reset busy", busy, 0);
        checkOutput("E reset bit_cnt", bitCnt, 0);
        checkOutput("E reset reg_shift", regShift, 0);
        checkOutput("E reset reg_par", regPar, 0);
        checkOutput("E reset reg_ser", regSer, 0);
        waitCycle(c0 + 9);
        reset_n = 1'b1;
        waitCycle(c0 + 11);
        checkOutput("E idle busy", busy, 0);
        checkOutput("E idle bit_cnt", bitCnt, 0);
        waitCycle(c0 + 30);

        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
